// File: rtl/demux_1a2_fifo.sv
// demux_1a2_fifo: splits an interleaved byte stream into two lanes by slot
// phase, buffering each lane in its own first-word-fall-through FIFO.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   data_in, valid_in          interleaved stream byte and its slot valid
//   pop_0, pop_1               consumer takes head of lane 0 / lane 1
//   data_out_0, data_out_1     head entry of each lane FIFO
//   valid_out_0, valid_out_1   lane FIFO non-empty
//   full_0, full_1             lane FIFO holds DEPTH entries
//   count_0, count_1           lane occupancy, 0..DEPTH
//   overflow_0, overflow_1     sticky: a valid byte was dropped on a full lane
//   slot                       lane written by the next edge
module demux_1a2_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   valid_in,
    input  logic                   pop_0,
    input  logic                   pop_1,
    output logic [DATA_W-1:0]      data_out_0,
    output logic [DATA_W-1:0]      data_out_1,
    output logic                   valid_out_0,
    output logic                   valid_out_1,
    output logic                   full_0,
    output logic                   full_1,
    output logic [$clog2(DEPTH):0] count_0,
    output logic [$clog2(DEPTH):0] count_1,
    output logic                   overflow_0,
    output logic                   overflow_1,
    output logic                   slot
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic              slot_q;
    logic [1:0]        push_req;
    logic [1:0]        pop_req;
    logic [1:0]        push_ok;
    logic [1:0]        pop_ok;
    logic [1:0]        ovf_q;
    logic [DATA_W-1:0] mem    [2][DEPTH];
    logic [PW-1:0]     wr_ptr [2];
    logic [PW-1:0]     rd_ptr [2];
    logic [CW-1:0]     cnt    [2];

    // Only the lane owning the current slot can see a push.
    assign push_req = {valid_in & slot_q, valid_in & ~slot_q};
    assign pop_req  = {pop_1, pop_0};

    // A pop on an empty lane is ignored; a push into a full lane is
    // accepted only when a pop frees the head in the same edge.
    always_comb begin
        push_ok = '0;
        pop_ok  = '0;
        for (int l = 0; l < 2; l++) begin
            pop_ok[l]  = pop_req[l] & (cnt[l] != '0);
            push_ok[l] = push_req[l] & ((cnt[l] != FULL_CNT) | pop_ok[l]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q <= 1'b0;
            ovf_q  <= '0;
            for (int l = 0; l < 2; l++) begin
                wr_ptr[l] <= '0;
                rd_ptr[l] <= '0;
                cnt[l]    <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem[l][i] <= '0;
                end
            end
        end else begin
            slot_q <= ~slot_q;
            for (int l = 0; l < 2; l++) begin
                if (push_ok[l]) begin
                    mem[l][wr_ptr[l]] <= data_in;
                    wr_ptr[l]         <= wr_ptr[l] + PW'(1);
                end
                if (pop_ok[l]) begin
                    rd_ptr[l] <= rd_ptr[l] + PW'(1);
                end
                if (push_ok[l] && !pop_ok[l]) begin
                    cnt[l] <= cnt[l] + CW'(1);
                end else if (pop_ok[l] && !push_ok[l]) begin
                    cnt[l] <= cnt[l] - CW'(1);
                end
                if (push_req[l] && !push_ok[l]) begin
                    ovf_q[l] <= 1'b1;
                end
            end
        end
    end

    assign data_out_0  = mem[0][rd_ptr[0]];
    assign data_out_1  = mem[1][rd_ptr[1]];
    assign valid_out_0 = (cnt[0] != '0);
    assign valid_out_1 = (cnt[1] != '0);
    assign full_0      = (cnt[0] == FULL_CNT);
    assign full_1      = (cnt[1] == FULL_CNT);
    assign count_0     = cnt[0];
    assign count_1     = cnt[1];
    assign overflow_0  = ovf_q[0];
    assign overflow_1  = ovf_q[1];
    assign slot        = slot_q;

endmodule

// File: tb/tb_demux_1a2_fifo.sv
// tb_demux_1a2_fifo: directed and randomized checks of demux_1a2_fifo
// against a queue-based lane model.
module tb_demux_1a2_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = '0;
    logic       valid_in = 1'b0;
    logic       pop_0 = 1'b0;
    logic       pop_1 = 1'b0;
    logic [7:0] data_out_0, data_out_1;
    logic       valid_out_0, valid_out_1;
    logic       full_0, full_1;
    logic [2:0] count_0, count_1;
    logic       overflow_0, overflow_1;
    logic       slot;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       m_ovf0, m_ovf1, m_slot;

    demux_1a2_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .data_in(data_in), .valid_in(valid_in),
        .pop_0(pop_0), .pop_1(pop_1),
        .data_out_0(data_out_0), .data_out_1(data_out_1),
        .valid_out_0(valid_out_0), .valid_out_1(valid_out_1),
        .full_0(full_0), .full_1(full_1),
        .count_0(count_0), .count_1(count_1),
        .overflow_0(overflow_0), .overflow_1(overflow_1),
        .slot(slot)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        q0.delete();
        q1.delete();
        m_ovf0 = 1'b0;
        m_ovf1 = 1'b0;
        m_slot = 1'b0;
    endtask

    // Apply one slot; the model follows the lane rules on the same edge.
    task automatic step(input logic v, input logic [7:0] d,
                        input logic p0, input logic p1);
        valid_in = v;
        data_in  = d;
        pop_0    = p0;
        pop_1    = p1;
        @(posedge clk);
        if (p0 && q0.size() != 0) void'(q0.pop_front());
        if (p1 && q1.size() != 0) void'(q1.pop_front());
        if (v) begin
            if (m_slot == 1'b0) begin
                if (q0.size() < DEPTH) q0.push_back(d);
                else m_ovf0 = 1'b1;
            end else begin
                if (q1.size() < DEPTH) q1.push_back(d);
                else m_ovf1 = 1'b1;
            end
        end
        m_slot = ~m_slot;
        #1;
        valid_in = 1'b0;
        pop_0    = 1'b0;
        pop_1    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        n_chk++;
        if ({count_0, count_1} !== 6'd0) begin
            n_err++;
            $display("FAIL rst_count: got %0d/%0d want 0/0", count_0, count_1);
        end
        n_chk++;
        if ({valid_out_0, valid_out_1, full_0, full_1,
             overflow_0, overflow_1, slot} !== 7'd0) begin
            n_err++;
            $display("FAIL rst_flags: got v%b%b f%b%b o%b%b s%b want 0",
                     valid_out_0, valid_out_1, full_0, full_1,
                     overflow_0, overflow_1, slot);
        end
        n_chk++;
        if ({data_out_0, data_out_1} !== 16'h0000) begin
            n_err++;
            $display("FAIL rst_data: got %h/%h want 00/00",
                     data_out_0, data_out_1);
        end
        #1;
        reset = 1'b0;
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        n_chk++;
        if (count_0 !== 3'd1 || count_1 !== 3'd0 || data_out_0 !== 8'hA5) begin
            n_err++;
            $display("FAIL rst_first_lane: got c0=%0d c1=%0d d0=%h want 1 0 a5",
                     count_0, count_1, data_out_0);
        end
        n_chk++;
        if (slot !== 1'b1) begin
            n_err++;
            $display("FAIL rst_slot_adv: got %b want 1", slot);
        end
    endtask

    task automatic test_basic();
        logic [7:0] e0 [2];
        logic [7:0] e1 [2];
        e0[0] = 8'h13; e0[1] = 8'h14;
        e1[0] = 8'hFD; e1[1] = 8'hFC;
        do_reset();
        step(1'b1, 8'h13, 1'b0, 1'b0);
        step(1'b1, 8'hFD, 1'b0, 1'b0);
        step(1'b1, 8'h14, 1'b0, 1'b0);
        step(1'b1, 8'hFC, 1'b0, 1'b0);
        n_chk++;
        if (count_0 !== 3'd2 || count_1 !== 3'd2) begin
            n_err++;
            $display("FAIL basic_count: got %0d/%0d want 2/2", count_0, count_1);
        end
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (data_out_0 !== e0[i] || data_out_1 !== e1[i]) begin
                n_err++;
                $display("FAIL basic_head%0d: got %h/%h want %h/%h",
                         i, data_out_0, data_out_1, e0[i], e1[i]);
            end
            step(1'b0, 8'h00, 1'b1, 1'b1);
        end
        n_chk++;
        if (valid_out_0 !== 1'b0 || valid_out_1 !== 1'b0) begin
            n_err++;
            $display("FAIL basic_drain: got v=%b%b want 00",
                     valid_out_0, valid_out_1);
        end
    endtask

    task automatic test_skip();
        do_reset();
        for (int i = 0; i < 8; i++)
            step((i % 2) == 0, (i % 2) == 0 ? 8'h15 : 8'hFB, 1'b0, 1'b0);
        n_chk++;
        if (count_0 !== 3'd4 || full_0 !== 1'b1 || valid_out_1 !== 1'b0) begin
            n_err++;
            $display("FAIL skip_fill: got c0=%0d f0=%b v1=%b want 4 1 0",
                     count_0, full_0, valid_out_1);
        end
        n_chk++;
        if (overflow_0 !== 1'b0) begin
            n_err++;
            $display("FAIL skip_no_ovf: got %b want 0", overflow_0);
        end
        step(1'b1, 8'h15, 1'b0, 1'b0);
        step(1'b0, 8'hFB, 1'b0, 1'b0);
        n_chk++;
        if (overflow_0 !== 1'b1 || count_0 !== 3'd4 || overflow_1 !== 1'b0) begin
            n_err++;
            $display("FAIL skip_ovf: got o0=%b c0=%0d o1=%b want 1 4 0",
                     overflow_0, count_0, overflow_1);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp [4];
        exp[0] = 8'hE1; exp[1] = 8'hE2; exp[2] = 8'hE3; exp[3] = 8'hF7;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hF7, 1'b0, 1'b1);
        n_chk++;
        if (count_1 !== 3'd4 || overflow_1 !== 1'b0 || full_1 !== 1'b1) begin
            n_err++;
            $display("FAIL fullpop_state: got c1=%0d o1=%b f1=%b want 4 0 1",
                     count_1, overflow_1, full_1);
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (data_out_1 !== exp[i] || valid_out_1 !== 1'b1) begin
                n_err++;
                $display("FAIL fullpop_head%0d: got %h v=%b want %h v=1",
                         i, data_out_1, valid_out_1, exp[i]);
            end
            step(1'b0, 8'h00, 1'b0, 1'b1);
        end
        n_chk++;
        if (valid_out_1 !== 1'b0 || count_1 !== 3'd0) begin
            n_err++;
            $display("FAIL fullpop_empty: got v1=%b c1=%0d want 0 0",
                     valid_out_1, count_1);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_chk++;
        if (count_0 !== 3'd0 || valid_out_0 !== 1'b0 || overflow_0 !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_empty_pop: got c0=%0d v0=%b o0=%b want 0 0 0",
                     count_0, valid_out_0, overflow_0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
            n_chk++;
            if (data_out_0 !== 8'(8'h20 + i) || count_0 !== 3'd1) begin
                n_err++;
                $display("FAIL wrap_byte%0d: got %h c0=%0d want %h c0=1",
                         i, data_out_0, count_0, 8'(8'h20 + i));
            end
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_chk++;
        if (count_0 !== 3'd0) begin
            n_err++;
            $display("FAIL wrap_end: got c0=%0d want 0", count_0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(i < 3, 8'(8'h30 + i), 1'b0, 1'b0);
            step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        end
        n_chk++;
        if (count_0 !== 3'd3 || overflow_1 !== 1'b1) begin
            n_err++;
            $display("FAIL mid_setup: got c0=%0d o1=%b want 3 1",
                     count_0, overflow_1);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        n_chk++;
        if (count_0 !== 3'd0 || count_1 !== 3'd0 || overflow_1 !== 1'b0 ||
            slot !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: got c=%0d/%0d o1=%b s=%b want 0 0 0 0",
                     count_0, count_1, overflow_1, slot);
        end
        #1;
        reset = 1'b0;
        step(1'b1, 8'h1B, 1'b0, 1'b0);
        n_chk++;
        if (count_0 !== 3'd1 || data_out_0 !== 8'h1B || count_1 !== 3'd0) begin
            n_err++;
            $display("FAIL mid_first: got c0=%0d d0=%h c1=%0d want 1 1b 0",
                     count_0, data_out_0, count_1);
        end
    endtask

    task automatic test_random();
        int pop_pct;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            pop_pct = (n < 200) ? 25 : 70;
            step($urandom_range(0, 99) < 80, 8'($urandom),
                 $urandom_range(0, 99) < pop_pct,
                 $urandom_range(0, 99) < pop_pct);
            n_chk++;
            if (count_0 !== 3'(q0.size()) || full_0 !== (q0.size() == DEPTH) ||
                valid_out_0 !== (q0.size() != 0) || overflow_0 !== m_ovf0) begin
                n_err++;
                $display("FAIL rnd_lane0 @%0d: got c=%0d f=%b v=%b o=%b want c=%0d o=%b",
                         n, count_0, full_0, valid_out_0, overflow_0,
                         q0.size(), m_ovf0);
            end
            n_chk++;
            if (count_1 !== 3'(q1.size()) || full_1 !== (q1.size() == DEPTH) ||
                valid_out_1 !== (q1.size() != 0) || overflow_1 !== m_ovf1) begin
                n_err++;
                $display("FAIL rnd_lane1 @%0d: got c=%0d f=%b v=%b o=%b want c=%0d o=%b",
                         n, count_1, full_1, valid_out_1, overflow_1,
                         q1.size(), m_ovf1);
            end
            if (q0.size() != 0) begin
                n_chk++;
                if (data_out_0 !== q0[0]) begin
                    n_err++;
                    $display("FAIL rnd_data0 @%0d: got %h want %h",
                             n, data_out_0, q0[0]);
                end
            end
            if (q1.size() != 0) begin
                n_chk++;
                if (data_out_1 !== q1[0]) begin
                    n_err++;
                    $display("FAIL rnd_data1 @%0d: got %h want %h",
                             n, data_out_1, q1[0]);
                end
            end
            n_chk++;
            if (slot !== m_slot) begin
                n_err++;
                $display("FAIL rnd_slot @%0d: got %b want %b", n, slot, m_slot);
            end
        end
    endtask

    initial begin
        model_clear();
        #12;
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
        m_slot = 1'b1;
        test_reset();
        test_basic();
        test_skip();
        test_full_pop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/demux_1a2_fifo.md
# demux_1a2_fifo

Inverse of the 2:1 byte interleaver. It takes the single interleaved 8-bit stream with its per-slot valid, de-interleaves it by alternating slot phase into lane 0 and lane 1, and buffers each lane in its own small FWFT FIFO. It sits on the receive side of the interleaved link, and downstream consumers drain each lane with a pop handshake.

## Interface
- DATA_W, 8, byte width of stream and lanes
- DEPTH, 4, entries per lane FIFO; power of two, at least 2
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- data_in  in  DATA_W  interleaved stream byte
- valid_in  in  1  byte in the current slot is valid
- pop_0 / pop_1  in  1  consumer takes the head entry of lane 0 / lane 1
- data_out_0 / data_out_1  out  DATA_W  head entry of each lane FIFO (FWFT)
- valid_out_0 / valid_out_1  out  1  lane FIFO is non-empty
- full_0 / full_1  out  1  lane FIFO holds DEPTH entries
- count_0 / count_1  out  log2(DEPTH)+1  occupancy of each lane FIFO
- overflow_0 / overflow_1  out  1  sticky flag: a valid byte was dropped because the lane was full
- slot  out  1  current slot phase: 0 = lane 0, 1 = lane 1

## Operation
- Phase: `slot` toggles on every rising edge. It is 0 on the first edge after reset deasserts, so lane 0 owns even edges and lane 1 owns odd edges. The phase never stalls and does not depend on valid_in.
- Push: at an edge, lane L = slot receives data_in if valid_in = 1. A byte with valid_in = 0 is discarded and the phase still advances.
- Each lane FIFO uses a circular buffer of DEPTH entries:
  - write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH;
  - a separate count register, 0..DEPTH.
- Pop: at an edge, if pop_L = 1 and valid_out_L = 1, the read pointer advances. A pop while empty is ignored: no pointer or count change, no error flag.
- Count update per lane:
  - push only: +1;
  - pop only: -1;
  - push and pop together: unchanged.
- Full lane:
  - A push with no simultaneous pop is dropped. overflow_L is set and the count stays DEPTH.
  - A push together with a pop is accepted, because the pop frees the slot in the same edge.
- Empty lane with a simultaneous push and pop: the pop is ignored (no valid head) and the push is accepted, so count becomes 1.
- overflow_L clears only on reset.
- Lanes are independent. At any edge only one lane can receive a push, but both lanes can pop.
- Reset (asynchronous, at any time, including mid-stream) drives:
  - slot = 0;
  - all pointers and counts = 0;
  - valid_out_L = 0, full_L = 0, overflow_L = 0;
  - data_out_L = 0 (storage is also cleared to 0).
  - Any byte in flight at the reset edge is lost.
- Derived outputs:
  - valid_out_L = (count_L != 0);
  - full_L = (count_L == DEPTH);
  - data_out_L = mem_L[rd_ptr_L].
  - All three come combinationally from registered state, so there is no path from input ports to outputs.

## Timing
- Push-to-visible latency is 1 cycle: a byte accepted at edge N appears on data_out_L with valid_out_L = 1 after edge N if the lane was empty.
- Pop takes effect at the edge. The next entry, or valid_out_L = 0, appears after that same edge.
- Maximum sustained throughput per lane is one byte every 2 cycles (half the stream rate).
- count, full and overflow all update at the same edge as the push or pop that causes them.
- slot after the edge tells which lane the next edge writes.

## Test plan
- Reset check: assert reset mid-cycle, asynchronously.
  - Expected: all outputs go to 0 at once, with no clock edge needed.
  - After deassert, the first edge writes lane 0.
- Basic de-interleave: stream 0x13 (valid), 0xFD (valid), 0x14 (valid), 0xFC (valid), no pops.
  - Expected lane 0: 0x13, 0x14; lane 1: 0xFD, 0xFC; count_0 = count_1 = 2.
  - Pops then return the bytes in that order.
- Slot skipping: lane 0 valid, lane 1 invalid for 8 slots with bytes 0x15/0xFB.
  - Expected: only lane 0 fills (count_0 = 4, full_0 = 1) and lane 1 stays empty.
  - The 5th lane-0 byte is dropped and sets overflow_0 = 1, with count_0 = 4.
- Full with simultaneous pop: fill lane 1 to DEPTH, then hold pop_1 = 1 while pushing 0xF7.
  - Expected: count_1 stays 4, overflow_1 stays 0, and 0xF7 is read last after 4 pops.
- Empty pop and wrap-around: pop an empty lane 0 (no change).
  - Then push and pop 10 bytes, 0x20 to 0x29, through lane 0.
  - Expected: data matches in order, confirming pointer wrap, and count ends at 0.
- Reset mid-operation: with count_0 = 3 and overflow_1 = 1, pulse reset.
  - Expected: counts and flags go to 0 and slot = 0.
  - The next valid byte 0x1B lands in lane 0.
